// File: rtl/adcfifo_sync_ctrl.sv
// Single-clock FIFO controller for the ADCFIFO LSRAM wrapper (SYNC=1, PIPE=1).
// Owns the RAM pointers and occupancy, and drives the flags and the read-valid strobe.
module adcfifo_sync_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned AWIDTH     = 7,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned AFULL_LVL  = 120,
  parameter int unsigned AEMPTY_LVL = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              WE,
  input  logic [WIDTH-1:0]  WDATA_IN,
  input  logic              RE,
  output logic [WIDTH-1:0]  RDATA_OUT,
  output logic              RVALID,
  output logic              FULL,
  output logic              EMPTY,
  output logic              AFULL,
  output logic              AEMPTY,
  output logic [AWIDTH:0]   COUNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
  output logic [AWIDTH-1:0] RAM_WADDR,
  output logic [WIDTH-1:0]  RAM_WDATA,
  output logic              RAM_WEN,
  output logic [AWIDTH-1:0] RAM_RADDR,
  output logic              RAM_REN,
  input  logic [WIDTH-1:0]  RAM_RDATA
);

  localparam int unsigned CW    = AWIDTH + 1;
  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [AWIDTH:0]       wptr;
  logic [AWIDTH:0]       rptr;
  logic [AWIDTH:0]       count_next;
  logic                  push_ok;
  logic                  pop_ok;
  logic [RD_LATENCY-1:0] rv_pipe;

  // Request gating against last cycle's flags; reset blocks all RAM access.
  always_comb begin
    push_ok    = WE & ~FULL & ~RESET;
    pop_ok     = RE & ~EMPTY & ~RESET;
    count_next = COUNT;
    if (push_ok && !pop_ok) begin
      count_next = COUNT + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = COUNT - CW'(1);
    end
  end

  assign RAM_WADDR = wptr[AWIDTH-1:0];
  assign RAM_RADDR = rptr[AWIDTH-1:0];
  assign RAM_WDATA = WDATA_IN;
  assign RAM_WEN   = push_ok;
  assign RAM_REN   = pop_ok;
  assign RDATA_OUT = RAM_RDATA;
  assign RVALID    = rv_pipe[RD_LATENCY-1];

  // Pointers, occupancy and flags; flags follow count_next so they track COUNT.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wptr      <= '0;
      rptr      <= '0;
      COUNT     <= '0;
      FULL      <= 1'b0;
      EMPTY     <= 1'b1;
      AFULL     <= 1'b0;
      AEMPTY    <= 1'b1;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
      rv_pipe   <= '0;
    end else begin
      if (push_ok) wptr <= wptr + CW'(1);
      if (pop_ok)  rptr <= rptr + CW'(1);
      COUNT     <= count_next;
      FULL      <= (count_next == CW'(DEPTH));
      EMPTY     <= (count_next == '0);
      AFULL     <= (count_next >= CW'(AFULL_LVL));
      AEMPTY    <= (count_next <= CW'(AEMPTY_LVL));
      OVERFLOW  <= WE & FULL;
      UNDERFLOW <= RE & EMPTY;
      rv_pipe   <= RD_LATENCY'({rv_pipe, pop_ok});
    end
  end

endmodule

// File: tb/tb_adcfifo_sync_ctrl.sv
// Directed bench for adcfifo_sync_ctrl with a two-stage pipelined RAM model.
module tb_adcfifo_sync_ctrl;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned AWIDTH = 7;
  localparam int unsigned DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [WIDTH-1:0]  wdata;
  logic              re;
  logic [WIDTH-1:0]  rdata_out;
  logic              rvalid, full, empty, afull, aempty, overflow, underflow;
  logic [AWIDTH:0]   count;
  logic [AWIDTH-1:0] ram_waddr, ram_raddr;
  logic [WIDTH-1:0]  ram_wdata, ram_rdata;
  logic              ram_wen, ram_ren;

  logic [WIDTH-1:0]  mem [0:DEPTH-1];
  logic [WIDTH-1:0]  rd_s1, rd_s2;
  logic [WIDTH-1:0]  q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int rx       = 0;
  int exp_cnt  = 0;
  int exp_wp   = 0;
  int exp_rp   = 0;

  always #5 clk = ~clk;

  adcfifo_sync_ctrl dut (
    .CLOCK(clk), .RESET(rst), .WE(we), .WDATA_IN(wdata), .RE(re),
    .RDATA_OUT(rdata_out), .RVALID(rvalid), .FULL(full), .EMPTY(empty),
    .AFULL(afull), .AEMPTY(aempty), .COUNT(count), .OVERFLOW(overflow),
    .UNDERFLOW(underflow), .RAM_WADDR(ram_waddr), .RAM_WDATA(ram_wdata),
    .RAM_WEN(ram_wen), .RAM_RADDR(ram_raddr), .RAM_REN(ram_ren),
    .RAM_RDATA(ram_rdata)
  );

  // LSRAM in SYNC=1, PIPE=1 mode: data two cycles after REN.
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) rd_s1 <= mem[ram_raddr];
    rd_s2 <= rd_s1;
  end
  assign ram_rdata = rd_s2;

  // Advance one cycle and score any returned word against the push order.
  task automatic tick();
    logic [WIDTH-1:0] e;
    @(posedge clk);
    #1;
    if (rvalid === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL rvalid_unexpected: RVALID=1 data=%h, required no pending pop", rdata_out);
      end else begin
        e = q.pop_front();
        rx++;
        if (rdata_out !== e) begin
          n_fail++;
          $display("FAIL rdata_order: got %h, required %h", rdata_out, e);
        end
      end
    end
  endtask

  task automatic check_flags(input string tag);
    n_checks++;
    if (count !== 8'(exp_cnt) || full !== (exp_cnt == 128) || empty !== (exp_cnt == 0) ||
        afull !== (exp_cnt >= 120) || aempty !== (exp_cnt <= 8)) begin
      n_fail++;
      $display("FAIL %s_flags: got count=%0d f=%b e=%b af=%b ae=%b, required count=%0d f=%b e=%b af=%b ae=%b",
               tag, count, full, empty, afull, aempty, exp_cnt, exp_cnt == 128, exp_cnt == 0,
               exp_cnt >= 120, exp_cnt <= 8);
    end
  endtask

  task automatic push_n(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      we = 1'b1;
      wdata = base + WIDTH'(i);
      #1;
      n_checks++;
      if (ram_wen !== 1'b1 || ram_waddr !== AWIDTH'(exp_wp)) begin
        n_fail++;
        $display("FAIL push_wen: got wen=%b waddr=%0d, required wen=1 waddr=%0d", ram_wen, ram_waddr, exp_wp);
      end
      q.push_back(wdata);
      exp_wp = (exp_wp + 1) % DEPTH;
      exp_cnt++;
      tick();
      we = 1'b0;
      check_flags("push");
    end
  endtask

  task automatic pop_n(input int n);
    int rx0;
    rx0 = rx;
    for (int i = 0; i < n; i++) begin
      re = 1'b1;
      #1;
      n_checks++;
      if (ram_ren !== 1'b1 || ram_raddr !== AWIDTH'(exp_rp)) begin
        n_fail++;
        $display("FAIL pop_ren: got ren=%b raddr=%0d, required ren=1 raddr=%0d", ram_ren, ram_raddr, exp_rp);
      end
      exp_rp = (exp_rp + 1) % DEPTH;
      exp_cnt--;
      tick();
      re = 1'b0;
      check_flags("pop");
    end
    tick();
    tick();
    n_checks++;
    if (rx - rx0 !== n) begin
      n_fail++;
      $display("FAIL pop_rvalid_count: got %0d, required %0d", rx - rx0, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; re = 1'b1; wdata = '0;
    #1;
    n_checks++;
    if (ram_wen !== 1'b0 || ram_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ram_gate: got wen=%b ren=%b, required 0 0", ram_wen, ram_ren);
    end
    tick();
    tick();
    rst = 1'b0; we = 1'b0; re = 1'b0;
    check_flags("reset");
    n_checks++;
    if (rvalid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || ram_waddr !== '0 || ram_raddr !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rv=%b ov=%b un=%b wa=%0d ra=%0d, required all 0",
               rvalid, overflow, underflow, ram_waddr, ram_raddr);
    end
    re = 1'b1;
    #1;
    n_checks++;
    if (ram_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_pop_ren: got %b, required 0", ram_ren);
    end
    tick();
    re = 1'b0;
    n_checks++;
    if (underflow !== 1'b1 || count !== '0) begin
      n_fail++;
      $display("FAIL underflow_pulse: got un=%b count=%0d, required 1 0", underflow, count);
    end
    tick();
    n_checks++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_clear: got %b, required 0", underflow);
    end
  endtask

  task automatic test_fill();
    push_n(128, 32'h0000_0001);
    we = 1'b1; wdata = 32'h0000_0081;
    #1;
    n_checks++;
    if (ram_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_wen: got %b, required 0", ram_wen);
    end
    tick();
    we = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || count !== 8'd128 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_pulse: got ov=%b count=%0d full=%b, required 1 128 1", overflow, count, full);
    end
    tick();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: got %b, required 0", overflow);
    end
  endtask

  // Cycle n is the cycle after the n-th edge; REN in cycle n-1 for n=1..128.
  task automatic test_drain();
    for (int n = 1; n <= 131; n++) begin
      re = (n <= 128);
      if (re) begin
        exp_rp = (exp_rp + 1) % DEPTH;
        exp_cnt--;
      end
      tick();
      re = 1'b0;
      n_checks++;
      if (rvalid !== (n >= 2 && n <= 129) || (rvalid === 1'b1 && rdata_out !== WIDTH'(n - 1))) begin
        n_fail++;
        $display("FAIL drain_latency: cycle %0d got rv=%b data=%h, required rv=%b data=%h",
                 n, rvalid, rdata_out, (n >= 2 && n <= 129), WIDTH'(n - 1));
      end
      check_flags("drain");
    end
  endtask

  task automatic test_wrap();
    push_n(100, 32'hA000_0000);
    pop_n(100);
    push_n(100, 32'hB000_0000);
    n_checks++;
    if (ram_waddr !== 7'd72) begin
      n_fail++;
      $display("FAIL wrap_waddr: got %0d, required 72", ram_waddr);
    end
    pop_n(100);
  endtask

  task automatic test_simultaneous();
    push_n(10, 32'hC000_0000);
    for (int i = 0; i < 50; i++) begin
      we = 1'b1; re = 1'b1; wdata = 32'hD000_0000 + WIDTH'(i);
      #1;
      n_checks++;
      if (ram_wen !== 1'b1 || ram_ren !== 1'b1) begin
        n_fail++;
        $display("FAIL simul_enables: got wen=%b ren=%b, required 1 1", ram_wen, ram_ren);
      end
      q.push_back(wdata);
      exp_wp = (exp_wp + 1) % DEPTH;
      exp_rp = (exp_rp + 1) % DEPTH;
      tick();
      check_flags("simul");
    end
    we = 1'b0; re = 1'b0;
    tick();
    tick();
    pop_n(10);
    push_n(128, 32'hE000_0000);
    we = 1'b1; re = 1'b1; wdata = 32'h0000_DEAD;
    #1;
    n_checks++;
    if (ram_wen !== 1'b0 || ram_ren !== 1'b1) begin
      n_fail++;
      $display("FAIL full_simul_enables: got wen=%b ren=%b, required 0 1", ram_wen, ram_ren);
    end
    exp_rp = (exp_rp + 1) % DEPTH;
    exp_cnt = 127;
    tick();
    we = 1'b0; re = 1'b0;
    n_checks++;
    if (count !== 8'd127 || overflow !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL full_simul: got count=%0d ov=%b full=%b, required 127 1 0", count, overflow, full);
    end
    tick();
    tick();
    tick();
    pop_n(127);
    we = 1'b1; re = 1'b1; wdata = 32'h0000_F00D;
    #1;
    n_checks++;
    if (ram_wen !== 1'b1 || ram_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_simul_enables: got wen=%b ren=%b, required 1 0", ram_wen, ram_ren);
    end
    q.push_back(wdata);
    exp_wp = (exp_wp + 1) % DEPTH;
    exp_cnt = 1;
    tick();
    we = 1'b0; re = 1'b0;
    n_checks++;
    if (count !== 8'd1 || underflow !== 1'b1 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_simul: got count=%0d un=%b empty=%b, required 1 1 0", count, underflow, empty);
    end
    pop_n(1);
  endtask

  task automatic test_reset_mid();
    push_n(41, 32'h1234_0000);
    re = 1'b1;
    tick();
    re = 1'b0;
    n_checks++;
    if (count !== 8'd40) begin
      n_fail++;
      $display("FAIL midreset_precount: got %0d, required 40", count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    exp_cnt = 0; exp_wp = 0; exp_rp = 0;
    check_flags("midreset");
    n_checks++;
    if (rvalid !== 1'b0 || ram_waddr !== '0 || ram_raddr !== '0) begin
      n_fail++;
      $display("FAIL midreset_state: got rv=%b wa=%0d ra=%0d, required 0 0 0", rvalid, ram_waddr, ram_raddr);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_rvalid: got %b, required 0", rvalid);
      end
    end
    push_n(3, 32'h5555_0000);
    pop_n(3);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; wdata = '0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
